cpu_port_arbiter: RTL

CPU_PORT_ARBITER -- requirements
Module: cpu_port_arbiter

---
 rtl/cpu_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpu_port_arbiter.sv
// Round-robin arbiter funnelling per-port CPU request queues onto a single
// cache port; one transaction in flight, completion acked back to its owner.
module cpu_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int Q_DEPTH = 4
) (
  input  logic                          c_clk,
  input  logic                          nReset,
  input  logic [N_PORTS*ADDR_W-1:0]     p_addr,
  input  logic [N_PORTS*DATA_W-1:0]     p_wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0] p_bval,
  input  logic [N_PORTS-1:0]            p_rd,
  input  logic [N_PORTS-1:0]            p_wr,
  output logic [N_PORTS-1:0]            p_full,
  output logic [N_PORTS-1:0]            p_ack,
  output logic [N_PORTS*DATA_W-1:0]     p_rdata,
  output logic [ADDR_W-1:0]             c_addr,
  output logic [DATA_W-1:0]             c_wdata,
  output logic [DATA_W/8-1:0]           c_bval,
  output logic                          c_rd,
  output logic                          c_wr,
  input  logic [DATA_W-1:0]             c_rdata,
  input  logic                          c_ack
);

  localparam int BV_W = DATA_W / 8;
  localparam int EW   = ADDR_W + DATA_W + BV_W + 2;
  localparam int PW   = $clog2(Q_DEPTH);
  localparam int GW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_reg, state_next;
  logic [N_PORTS-1:0] push, pop, nonempty;
  logic [EW-1:0]     head [N_PORTS];
  logic [GW-1:0]     last_grant_reg, owner_reg, grant_idx, cand;
  logic              grant_found;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic [EW-1:0] mem [Q_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [EW-1:0] entry;

    // A combined rd+wr strobe is queued as a plain read with its data dropped.
    assign push[gi] = nReset & (p_rd[gi] | p_wr[gi]) & ~p_full[gi];
    assign entry = {p_addr[gi*ADDR_W +: ADDR_W],
                    p_rd[gi] ? {DATA_W{1'b0}} : p_wdata[gi*DATA_W +: DATA_W],
                    p_bval[gi*BV_W +: BV_W],
                    p_rd[gi],
                    p_wr[gi] & ~p_rd[gi]};

    always_ff @(posedge c_clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= entry;
    end

    always_ff @(posedge c_clk) begin
      if (!nReset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        case ({push[gi], pop[gi]})
          2'b10:   count_reg <= count_reg + (PW+1)'(1);
          2'b01:   count_reg <= count_reg - (PW+1)'(1);
          default: ;
        endcase
      end
    end

    assign head[gi]     = mem[rd_ptr_reg];
    assign nonempty[gi] = (count_reg != '0);
    assign p_full[gi]   = (count_reg == (PW+1)'(Q_DEPTH));
  end

  always_ff @(posedge c_clk) begin
    if (!nReset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    pop         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    // Search upward from the port after the last grant, wrapping at the top.
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = GW'((int'(last_grant_reg) + k) % N_PORTS);
      if (!grant_found && nonempty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next     = ISSUE;
          pop[grant_idx] = 1'b1;
        end
      end
      ISSUE: begin
        if (c_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!nReset) begin
      c_addr         <= '0;
      c_wdata        <= '0;
      c_bval         <= '0;
      c_rd           <= 1'b0;
      c_wr           <= 1'b0;
      p_ack          <= '0;
      p_rdata        <= '0;
      owner_reg      <= '0;
      last_grant_reg <= GW'(N_PORTS - 1);
    end else begin
      p_ack <= '0;
      if (state_reg == IDLE && grant_found) begin
        {c_addr, c_wdata, c_bval, c_rd, c_wr} <= head[grant_idx];
        owner_reg      <= grant_idx;
        last_grant_reg <= grant_idx;
      end
      if (state_reg == ISSUE && c_ack) begin
        c_rd <= 1'b0;
        c_wr <= 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
          if (owner_reg == GW'(i)) begin
            p_ack[i] <= 1'b1;
            if (c_rd) p_rdata[i*DATA_W +: DATA_W] <= c_rdata;
          end
        end
      end
    end
  end

endmodule
